cpu_step_ctrl: RTL and testbench
================================

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before the step-button level is accepted.
REQ-002 Parameter RUN_DIV, default 12000000: clock cycles per cpu_en pulse in run mode; legal range 2..2^24-1.
REQ-003 Port clk  input  1  system clock; the only clock; all logic rising-edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port mode  input  1  0 = free-run, 1 = single-step; synchronous to clk (driven by the mode toggle stage).
REQ-006 Port n_step  input  1  raw step push-button, active-low, asynchronous, bouncy.
REQ-007 Port halt  input  1  halt request from CPU core, level, synchronous to clk.
REQ-008 Port cpu_en  output  1  CPU clock-enable, one-cycle pulse per CPU step, registered.
REQ-009 Port running  output  1  high while in state RUN, registered.
REQ-010 Port halted  output  1  high while in state HALTED, registered.
REQ-011 Port step_count  output  16  number of cpu_en pulses issued since reset, registered.

Function
REQ-012 n_step SHALL pass through a 2-flop synchroniser before any other use.
REQ-013 Debounced level SHALL update to the synchronised level only after it has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced level clears the counter.
REQ-014 A press event SHALL be a one-cycle flag asserted on the cycle after the debounced level goes 1->0; release (0->1) generates no event.
REQ-015 FSM states: STEP_WAIT, STEP_PULSE, RUN, HALTED; transition priority per cycle: halt > mode > press event.
REQ-016 STEP_WAIT: halt=1 -> HALTED; else mode=0 -> RUN; else press event -> STEP_PULSE; else stay.
REQ-017 STEP_PULSE: cpu_en=1 for exactly this one cycle; next state STEP_WAIT unconditionally (halt takes effect from STEP_WAIT).
REQ-018 RUN: 24-bit divider counts 0..RUN_DIV-1 and wraps to 0; cpu_en=1 in the cycle the divider equals RUN_DIV-1; halt=1 -> HALTED; mode=1 -> STEP_WAIT; press events ignored and not queued.
REQ-019 Leaving RUN for any reason SHALL clear the divider to 0 and suppress cpu_en in that cycle; re-entering RUN starts a full RUN_DIV period.
REQ-020 HALTED: cpu_en=0; exit only when halt=0 and a press event occurs -> STEP_WAIT (regardless of mode); press events while halt=1 are discarded.
REQ-021 cpu_en SHALL never be high on two consecutive cycles in step mode and never high in HALTED.
REQ-022 step_count SHALL increment by 1 on each cpu_en pulse, wrapping 0xFFFF -> 0x0000.
REQ-023 running and halted SHALL be registered decodes of the FSM state, updating with the state.

Reset
REQ-024 rst=1 at a clock edge SHALL force: state STEP_WAIT, cpu_en=0, running=0, halted=0, step_count=0, divider=0, debounce counter=0, debounced level=1, synchroniser flops=1, press flag=0.
REQ-025 Reset asserted mid-operation (any state, mid-debounce, mid-divide) SHALL override all transitions in that cycle; first transition evaluated on the first edge with rst=0.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=5)
REQ-026 Reset, mode=1, hold n_step=0 stable -> exactly one cpu_en pulse; step_count=1; holding longer gives no further pulse.
REQ-027 mode=1, n_step glitches low for 3 cycles then high -> no cpu_en, step_count stays 0.
REQ-028 mode=0 for 20 cycles after reset -> cpu_en every 5th cycle in RUN, running=1, step_count=4; n_step presses during RUN produce no extra pulses.
REQ-029 RUN, assert halt for 1 cycle mid-period -> halted=1, cpu_en stays 0; press with halt=0 -> STEP_WAIT, halted=0; with mode=0, RUN resumes and first cpu_en arrives 5 cycles after entering RUN.
REQ-030 Preload step_count=0xFFFF via 65535 run pulses, one more pulse -> step_count=0x0000; assert rst mid-divide -> all outputs 0 on next edge.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// CPU step/run clock-enable controller.
// Debounced step button, free-run divider, halt handling.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned RUN_DIV         = 12000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        n_step,
  input  logic        halt,
  output logic        cpu_en,
  output logic        running,
  output logic        halted,
  output logic [15:0] step_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] DIV_LAST = 24'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_STEP_WAIT,
    S_STEP_PULSE,
    S_RUN,
    S_HALTED
  } state_t;

  logic           r_sync1;
  logic           r_sync2;
  logic           r_db_lvl;
  logic [DBW-1:0] r_db_cnt;
  logic           r_press;
  state_t         r_state;
  state_t         w_next;
  logic [23:0]    r_div;
  logic [23:0]    w_div_next;
  logic           w_en_next;
  logic           r_cpu_en;
  logic           r_running;
  logic           r_halted;
  logic [15:0]    r_step_cnt;

  // Press fires only on a debounced 1->0 edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_db_lvl <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= n_step;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_db_lvl) begin
        if (r_db_cnt == DB_LAST) begin
          r_db_lvl <= r_sync2;
          r_db_cnt <= '0;
          r_press  <= ~r_sync2;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_STEP_WAIT: begin
        if (halt)         w_next = S_HALTED;
        else if (!mode)   w_next = S_RUN;
        else if (r_press) w_next = S_STEP_PULSE;
      end
      S_STEP_PULSE: w_next = S_STEP_WAIT;
      S_RUN: begin
        if (halt)      w_next = S_HALTED;
        else if (mode) w_next = S_STEP_WAIT;
      end
      S_HALTED: begin
        if (!halt && r_press) w_next = S_STEP_WAIT;
      end
      default: w_next = S_STEP_WAIT;
    endcase
  end

  // Divider only advances while staying in RUN; any entry starts at 0.
  always_comb begin
    w_div_next = '0;
    if (r_state == S_RUN && w_next == S_RUN) begin
      if (r_div == DIV_LAST) w_div_next = '0;
      else                   w_div_next = r_div + 24'd1;
    end
    w_en_next = (w_next == S_STEP_PULSE) ||
                (w_next == S_RUN && w_div_next == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_STEP_WAIT;
      r_div      <= '0;
      r_cpu_en   <= 1'b0;
      r_running  <= 1'b0;
      r_halted   <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_div      <= w_div_next;
      r_cpu_en   <= w_en_next;
      r_running  <= (w_next == S_RUN);
      r_halted   <= (w_next == S_HALTED);
      r_step_cnt <= r_step_cnt + {15'd0, w_en_next};
    end
  end

  assign cpu_en     = r_cpu_en;
  assign running    = r_running;
  assign halted     = r_halted;
  assign step_count = r_step_cnt;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl.
// Runs with DEBOUNCE_CYCLES=4, RUN_DIV=5.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b1;
  logic        n_step = 1'b1;
  logic        halt = 1'b0;
  logic        cpu_en;
  logic        running;
  logic        halted;
  logic [15:0] step_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .n_step(n_step),
    .halt(halt),
    .cpu_en(cpu_en),
    .running(running),
    .halted(halted),
    .step_count(step_count)
  );

  task automatic tick(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (cpu_en === 1'b1) pulses++;
    end
  endtask

  task automatic do_reset(input logic m);
    int p;
    rst = 1'b1;
    mode = m;
    halt = 1'b0;
    n_step = 1'b1;
    tick(2, p);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int p;
    rst = 1'b1;
    tick(1, p);
    n_checks++;
    if ({cpu_en, running, halted, step_count} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got en=%b run=%b hlt=%b cnt=%h want all 0",
               cpu_en, running, halted, step_count);
    end
  endtask

  task automatic test_step_press;
    int p;
    do_reset(1'b1);
    n_step = 1'b0;
    tick(20, p);
    n_checks++;
    if (p !== 1 || step_count !== 16'd1) begin
      n_errors++;
      $display("FAIL step_press got pulses=%0d cnt=%0d want 1/1", p, step_count);
    end
    tick(20, p);
    n_checks++;
    if (p !== 0 || step_count !== 16'd1) begin
      n_errors++;
      $display("FAIL step_hold got pulses=%0d cnt=%0d want 0/1", p, step_count);
    end
    n_step = 1'b1;
    tick(12, p);
    n_checks++;
    if (p !== 0 || running !== 1'b0 || halted !== 1'b0) begin
      n_errors++;
      $display("FAIL step_release got p=%0d run=%b hlt=%b want 0/0/0",
               p, running, halted);
    end
  endtask

  task automatic test_glitch;
    int p1, p2;
    do_reset(1'b1);
    n_step = 1'b0;
    tick(3, p1);
    n_step = 1'b1;
    tick(15, p2);
    n_checks++;
    if (p1 + p2 !== 0 || step_count !== 16'd0) begin
      n_errors++;
      $display("FAIL glitch3 got pulses=%0d cnt=%0d want 0/0", p1 + p2, step_count);
    end
    n_step = 1'b0;
    tick(4, p1);
    n_step = 1'b1;
    tick(15, p2);
    n_checks++;
    if (p1 + p2 !== 1 || step_count !== 16'd1) begin
      n_errors++;
      $display("FAIL glitch4 got pulses=%0d cnt=%0d want 1/1", p1 + p2, step_count);
    end
  endtask

  task automatic test_run;
    int p1, p2;
    do_reset(1'b0);
    tick(21, p1);
    n_checks++;
    if (p1 !== 4 || step_count !== 16'd4 || running !== 1'b1) begin
      n_errors++;
      $display("FAIL run_20 got pulses=%0d cnt=%0d run=%b want 4/4/1",
               p1, step_count, running);
    end
    n_step = 1'b0;
    tick(20, p1);
    n_step = 1'b1;
    tick(20, p2);
    n_checks++;
    if (p1 + p2 !== 8 || step_count !== 16'd12) begin
      n_errors++;
      $display("FAIL run_press got pulses=%0d cnt=%0d want 8/12",
               p1 + p2, step_count);
    end
  endtask

  task automatic test_halt;
    int p, k;
    tick(2, p);
    halt = 1'b1;
    tick(1, p);
    halt = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || running !== 1'b0 || cpu_en !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_enter got hlt=%b run=%b en=%b want 1/0/0",
               halted, running, cpu_en);
    end
    tick(10, p);
    n_checks++;
    if (p !== 0 || halted !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_hold got pulses=%0d hlt=%b want 0/1", p, halted);
    end
    halt = 1'b1;
    n_step = 1'b0;
    tick(12, p);
    n_step = 1'b1;
    tick(12, k);
    halt = 1'b0;
    tick(3, k);
    n_checks++;
    if (p !== 0 || halted !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_press_discard got pulses=%0d hlt=%b want 0/1", p, halted);
    end
    n_step = 1'b0;
    for (int i = 0; i < 30 && halted === 1'b1; i++) tick(1, p);
    n_checks++;
    if (halted !== 1'b0 || running !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_exit got hlt=%b run=%b want 0/0", halted, running);
    end
    tick(1, p);
    n_checks++;
    if (running !== 1'b1 || cpu_en !== 1'b0) begin
      n_errors++;
      $display("FAIL run_resume got run=%b en=%b want 1/0", running, cpu_en);
    end
    k = 0;
    for (int i = 0; i < 10 && cpu_en !== 1'b1; i++) begin
      tick(1, p);
      k++;
    end
    n_checks++;
    if (k !== 4 || cpu_en !== 1'b1) begin
      n_errors++;
      $display("FAIL run_first_pulse got edges=%0d want 4", k);
    end
    n_step = 1'b1;
    tick(12, p);
  endtask

  task automatic test_mode_switch;
    int p;
    logic [15:0] c0;
    mode = 1'b1;
    tick(1, p);
    n_checks++;
    if (running !== 1'b0 || halted !== 1'b0) begin
      n_errors++;
      $display("FAIL mode_to_step got run=%b hlt=%b want 0/0", running, halted);
    end
    c0 = step_count;
    n_step = 1'b0;
    tick(15, p);
    n_step = 1'b1;
    tick(12, p);
    n_checks++;
    if (step_count !== c0 + 16'd1) begin
      n_errors++;
      $display("FAIL mode_step_press got cnt=%0d want %0d", step_count, c0 + 16'd1);
    end
    mode = 1'b0;
    tick(1, p);
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++;
      $display("FAIL mode_to_run got run=%b want 1", running);
    end
  endtask

  task automatic test_wrap;
    int p;
    for (int i = 0; i < 10 && cpu_en !== 1'b1; i++) tick(1, p);
    force dut.r_step_cnt = 16'hFFFE;
    #1;
    release dut.r_step_cnt;
    tick(1, p);
    for (int i = 0; i < 10 && cpu_en !== 1'b1; i++) tick(1, p);
    n_checks++;
    if (step_count !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL wrap_ffff got cnt=%h want ffff", step_count);
    end
    tick(1, p);
    for (int i = 0; i < 10 && cpu_en !== 1'b1; i++) tick(1, p);
    n_checks++;
    if (step_count !== 16'h0000) begin
      n_errors++;
      $display("FAIL wrap_0000 got cnt=%h want 0000", step_count);
    end
  endtask

  task automatic test_reset_mid;
    int p, k;
    tick(2, p);
    rst = 1'b1;
    tick(1, p);
    n_checks++;
    if ({cpu_en, running, halted, step_count} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_mid got en=%b run=%b hlt=%b cnt=%h want all 0",
               cpu_en, running, halted, step_count);
    end
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 12 && cpu_en !== 1'b1; i++) begin
      tick(1, p);
      k++;
    end
    n_checks++;
    if (k !== 5 || step_count !== 16'd1) begin
      n_errors++;
      $display("FAIL reset_mid_restart got edges=%0d cnt=%0d want 5/1", k, step_count);
    end
  endtask

  initial begin
    test_reset();
    test_step_press();
    test_glitch();
    test_run();
    test_halt();
    test_mode_switch();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
